hwpf_issue_ctrl: RTL and testbench



---
 rtl/hwpf_pkg.sv | 40 ++++
 rtl/hwpf_outstanding_table.sv | 93 +++++++++
 rtl/hwpf_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_hwpf_issue_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwpf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hwpf_pkg
// Brief   : Shared types and helpers for the next-line prefetch issue stage.
// Rev     : 1.0 - initial release
// ============================================================================
package hwpf_pkg;

  localparam int unsigned HWPF_ADDR_WIDTH = 40;
  localparam int unsigned HWPF_TID_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    HOLD      = 2'd2
  } hwpf_issue_state_t;

  typedef struct packed {
    logic                       valid;
    logic [HWPF_ADDR_WIDTH-1:0] addr;
  } req_cpu_dcache_t;

  typedef struct packed {
    logic                       valid;
    logic [HWPF_TID_WIDTH-1:0]  tid;
    logic [HWPF_ADDR_WIDTH-1:0] addr;
  } hwpf_outstanding_entry_t;

  // lane_size must be a power of two
  function automatic logic [HWPF_ADDR_WIDTH-1:0] line_addr(
    input logic [HWPF_ADDR_WIDTH-1:0] addr,
    input int unsigned                lane_size
  );
    logic [HWPF_ADDR_WIDTH-1:0] w_mask;
    w_mask = ~(HWPF_ADDR_WIDTH'(lane_size) - HWPF_ADDR_WIDTH'(1));
    return addr & w_mask;
  endfunction

endpackage : hwpf_pkg
`default_nettype wire

// File: rtl/hwpf_outstanding_table.sv
`default_nettype none
// ============================================================================
// Module  : hwpf_outstanding_table
// Brief   : Tracks in-flight prefetch TIDs (and line addresses when
//           HWPF_ISSUE_DEDUP_EN is defined); allocate, free by TID, count.
// Rev     : 1.0 - initial release
// ============================================================================
module hwpf_outstanding_table
  import hwpf_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TID_WIDTH       = 4,
  parameter int unsigned ADDR_WIDTH      = 40
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   alloc_i,
  input  logic [TID_WIDTH-1:0]                   alloc_tid_i,
`ifdef HWPF_ISSUE_DEDUP_EN
  input  logic [ADDR_WIDTH-1:0]                  alloc_addr_i,
  input  logic [ADDR_WIDTH-1:0]                  match_addr_i,
  output logic                                   match_o,
`endif
  input  logic                                   free_i,
  input  logic [TID_WIDTH-1:0]                   free_tid_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   count_o,
  output logic                                   full_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING+1);

  logic [MAX_OUTSTANDING-1:0] r_vld;
  logic [TID_WIDTH-1:0]       r_tid [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] w_alloc_sel;
  logic [MAX_OUTSTANDING-1:0] w_free_hit;

  // Lowest free slot wins the allocation
  always_comb begin
    logic v_found;
    v_found     = 1'b0;
    w_alloc_sel = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (!r_vld[i] && !v_found) begin
        w_alloc_sel[i] = 1'b1;
        v_found        = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < MAX_OUTSTANDING; g++) begin : g_hit
    assign w_free_hit[g] = free_i && r_vld[g] && (r_tid[g] == free_tid_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_tid[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (alloc_i && w_alloc_sel[i]) begin
          r_vld[i] <= 1'b1;
          r_tid[i] <= alloc_tid_i;
        end else if (w_free_hit[i]) begin
          r_vld[i] <= 1'b0;
        end
      end
    end
  end

`ifdef HWPF_ISSUE_DEDUP_EN
  logic [ADDR_WIDTH-1:0] r_addr [MAX_OUTSTANDING];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_addr[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        if (alloc_i && w_alloc_sel[i]) r_addr[i] <= alloc_addr_i;
    end
  end

  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++)
      if (r_vld[i] && (r_addr[i] == match_addr_i)) match_o = 1'b1;
  end
`endif

  assign count_o = CNT_W'($countones(r_vld));
  assign full_o  = (count_o == CNT_W'(MAX_OUTSTANDING));

endmodule : hwpf_outstanding_table
`default_nettype wire

// File: rtl/hwpf_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hwpf_issue_ctrl
// Brief   : Pops prefetch queue entries, holds one and issues it to the
//           HPDcache with TID tagging, timeout drop and optional dedup
//           (HWPF_ISSUE_DEDUP_EN).
// Rev     : 1.0 - initial release
// ============================================================================
module hwpf_issue_ctrl
  import hwpf_pkg::*;
#(
  parameter type         cpu_addr_t      = req_cpu_dcache_t,
  parameter int unsigned ADDR_WIDTH      = 40,
  parameter int unsigned LANE_SIZE       = 64,
  parameter int unsigned TID_WIDTH       = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned HOLD_TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  demand_valid_i,
  output logic                  fifo_read_o,
  input  logic                  fifo_req_valid_i,
  input  cpu_addr_t             fifo_req_i,
  output logic                  pf_req_valid_o,
  input  logic                  pf_req_ready_i,
  output logic [ADDR_WIDTH-1:0] pf_req_addr_o,
  output logic [TID_WIDTH-1:0]  pf_req_tid_o,
  input  logic                  pf_rsp_valid_i,
  input  logic [TID_WIDTH-1:0]  pf_rsp_tid_i,
  output logic                  drop_o,
  output logic                  busy_o
);

  localparam logic [1:0] c_st_idle = IDLE;
  localparam logic [1:0] c_st_wait = WAIT_DATA;
  localparam logic [1:0] c_st_hold = HOLD;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int unsigned TMR_W = $clog2(HOLD_TIMEOUT+1);

  logic [1:0]                 r_state;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [TID_WIDTH-1:0]       r_tid;
  logic [TMR_W-1:0]           r_timer;
  logic                       r_asserted;
  logic                       r_drop;
  logic [CNT_W-1:0]           w_count;
  logic                       w_full;
  logic                       w_issue;
  logic                       w_capture;
  logic                       w_dup;
  logic [HWPF_ADDR_WIDTH-1:0] w_line;

  assign w_line    = line_addr(fifo_req_i.addr, LANE_SIZE);
  assign w_capture = fifo_req_valid_i && fifo_req_i.valid;

  // Valid is gated by demand only until first shown; after that it is held
  assign pf_req_valid_o = (r_state == c_st_hold) && (r_asserted || !demand_valid_i);
  assign w_issue        = pf_req_valid_o && pf_req_ready_i;
  assign fifo_read_o    = !rst_i && (r_state == c_st_idle) && !w_full && !flush_i;
  assign pf_req_addr_o  = r_addr;
  assign pf_req_tid_o   = r_tid;
  assign drop_o         = r_drop;
  assign busy_o         = (r_state != c_st_idle) || (w_count != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= c_st_idle;
      r_addr     <= '0;
      r_tid      <= '0;
      r_timer    <= '0;
      r_asserted <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (fifo_read_o) r_state <= c_st_wait;
        end
        c_st_wait: begin
          r_state <= c_st_idle;
          if (!flush_i && w_capture) begin
            if (w_dup) begin
              r_drop <= 1'b1;
            end else begin
              r_addr     <= w_line[ADDR_WIDTH-1:0];
              r_timer    <= '0;
              r_asserted <= 1'b0;
              r_state    <= c_st_hold;
            end
          end
        end
        c_st_hold: begin
          // A handshake completing under flush is still recorded
          if (w_issue) begin
            r_tid      <= r_tid + TID_WIDTH'(1);
            r_asserted <= 1'b0;
            r_timer    <= '0;
            r_state    <= c_st_idle;
          end else if (flush_i) begin
            r_asserted <= 1'b0;
            r_timer    <= '0;
            r_state    <= c_st_idle;
          end else if (pf_req_valid_o) begin
            r_asserted <= 1'b1;
          end else if (r_timer == TMR_W'(HOLD_TIMEOUT-1)) begin
            r_drop  <= 1'b1;
            r_timer <= '0;
            r_state <= c_st_idle;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  hwpf_outstanding_table #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TID_WIDTH       (TID_WIDTH),
    .ADDR_WIDTH      (ADDR_WIDTH)
  ) u_table (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .alloc_i      (w_issue),
    .alloc_tid_i  (r_tid),
`ifdef HWPF_ISSUE_DEDUP_EN
    .alloc_addr_i (r_addr),
    .match_addr_i (w_line[ADDR_WIDTH-1:0]),
    .match_o      (w_dup),
`endif
    .free_i       (pf_rsp_valid_i),
    .free_tid_i   (pf_rsp_tid_i),
    .count_o      (w_count),
    .full_o       (w_full)
  );

`ifndef HWPF_ISSUE_DEDUP_EN
  assign w_dup = 1'b0;
`endif

endmodule : hwpf_issue_ctrl
`default_nettype wire

// File: tb/tb_hwpf_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hwpf_issue_ctrl
// Brief   : Directed and randomized bench for hwpf_issue_ctrl against a
//           queue-based reference model (honours HWPF_ISSUE_DEDUP_EN).
// Rev     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hwpf_issue_ctrl;
  import hwpf_pkg::*;

  localparam int unsigned ADDR_WIDTH      = 40;
  localparam int unsigned LANE_SIZE       = 64;
  localparam int unsigned TID_WIDTH       = 4;
  localparam int unsigned MAX_OUTSTANDING = 4;
  localparam int unsigned HOLD_TIMEOUT    = 16;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  flush_i;
  logic                  demand_valid_i;
  logic                  fifo_read_o;
  logic                  fifo_req_valid_i;
  req_cpu_dcache_t       fifo_req_i;
  logic                  pf_req_valid_o;
  logic                  pf_req_ready_i;
  logic [ADDR_WIDTH-1:0] pf_req_addr_o;
  logic [TID_WIDTH-1:0]  pf_req_tid_o;
  logic                  pf_rsp_valid_i;
  logic [TID_WIDTH-1:0]  pf_rsp_tid_i;
  logic                  drop_o;
  logic                  busy_o;

  always #5 clk_i = ~clk_i;

  hwpf_issue_ctrl #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .LANE_SIZE       (LANE_SIZE),
    .TID_WIDTH       (TID_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .HOLD_TIMEOUT    (HOLD_TIMEOUT)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .demand_valid_i   (demand_valid_i),
    .fifo_read_o      (fifo_read_o),
    .fifo_req_valid_i (fifo_req_valid_i),
    .fifo_req_i       (fifo_req_i),
    .pf_req_valid_o   (pf_req_valid_o),
    .pf_req_ready_i   (pf_req_ready_i),
    .pf_req_addr_o    (pf_req_addr_o),
    .pf_req_tid_o     (pf_req_tid_o),
    .pf_rsp_valid_i   (pf_rsp_valid_i),
    .pf_rsp_tid_i     (pf_rsp_tid_i),
    .drop_o           (drop_o),
    .busy_o           (busy_o)
  );

  typedef struct {
    logic [TID_WIDTH-1:0]  tid;
    logic [ADDR_WIDTH-1:0] addr;
  } ent_t;

  // Reference model: in-flight list plus a description of the one pending request
  ent_t                  m_out[$];
  int unsigned           m_next_tid;
  bit                    m_popped;
  bit                    m_held;
  bit                    m_shown;
  bit                    m_drop;
  int                    m_waited;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [ADDR_WIDTH-1:0] line_mask;

  logic                  s_read, s_valid, s_drop, s_busy;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [TID_WIDTH-1:0]  s_tid;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_out.delete();
    m_next_tid = 0;
    m_popped   = 1'b0;
    m_held     = 1'b0;
    m_shown    = 1'b0;
    m_drop     = 1'b0;
    m_waited   = 0;
    m_addr     = '0;
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    flush_i = 1'b0; demand_valid_i = 1'b0; fifo_req_valid_i = 1'b0;
    fifo_req_i = '0; pf_req_ready_i = 1'b0; pf_rsp_valid_i = 1'b0; pf_rsp_tid_i = '0;
    #1;
    check_eq("rst_fifo_read", 64'(fifo_read_o), 64'd0);
    check_eq("rst_pf_valid", 64'(pf_req_valid_o), 64'd0);
    check_eq("rst_pf_addr", 64'(pf_req_addr_o), 64'd0);
    check_eq("rst_pf_tid", 64'(pf_req_tid_o), 64'd0);
    check_eq("rst_drop", 64'(drop_o), 64'd0);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    model_reset();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic step(input logic dem, input logic fl, input logic fvld,
                      input logic [ADDR_WIDTH-1:0] faddr, input logic rdy,
                      input logic rv, input logic [TID_WIDTH-1:0] rtid);
    bit e_read, e_valid, e_busy, hs, dup;
    logic [ADDR_WIDTH-1:0] line;
    ent_t e;
    @(negedge clk_i);
    demand_valid_i = dem; flush_i = fl; fifo_req_valid_i = fvld;
    fifo_req_i.valid = fvld; fifo_req_i.addr = faddr;
    pf_req_ready_i = rdy; pf_rsp_valid_i = rv; pf_rsp_tid_i = rtid;
    #1;
    e_read  = !m_held && !m_popped && (m_out.size() < MAX_OUTSTANDING) && !fl;
    e_valid = m_held && (m_shown || !dem);
    e_busy  = m_popped || m_held || (m_out.size() != 0);
    s_read = fifo_read_o; s_valid = pf_req_valid_o; s_drop = drop_o;
    s_busy = busy_o; s_addr = pf_req_addr_o; s_tid = pf_req_tid_o;
    check_eq("fifo_read", 64'(fifo_read_o), 64'(e_read));
    check_eq("pf_valid", 64'(pf_req_valid_o), 64'(e_valid));
    check_eq("busy", 64'(busy_o), 64'(e_busy));
    check_eq("drop", 64'(drop_o), 64'(m_drop));
    if (e_valid) begin
      check_eq("pf_addr", 64'(pf_req_addr_o), 64'(m_addr));
      check_eq("pf_tid", 64'(pf_req_tid_o), 64'(m_next_tid));
    end
    hs   = e_valid && rdy;
    line = faddr & line_mask;
    dup  = 1'b0;
`ifdef HWPF_ISSUE_DEDUP_EN
    foreach (m_out[i]) if (m_out[i].addr == line) dup = 1'b1;
`endif
    @(posedge clk_i);
    cyc++;
    m_drop = 1'b0;
    if (rv) begin
      for (int i = 0; i < m_out.size(); i++) begin
        if (m_out[i].tid == rtid) begin
          m_out.delete(i);
          break;
        end
      end
    end
    if (m_popped) begin
      m_popped = 1'b0;
      if (!fl && fvld) begin
        if (dup) m_drop = 1'b1;
        else begin
          m_held = 1'b1; m_addr = line; m_waited = 0; m_shown = 1'b0;
        end
      end
    end else if (m_held) begin
      if (hs) begin
        e.tid  = TID_WIDTH'(m_next_tid);
        e.addr = m_addr;
        m_out.push_back(e);
        m_next_tid = (m_next_tid + 1) % (1 << TID_WIDTH);
        m_held = 1'b0;
      end else if (fl) begin
        m_held = 1'b0;
      end else if (e_valid) begin
        m_shown = 1'b1;
      end else begin
        m_waited++;
        if (m_waited == HOLD_TIMEOUT) begin
          m_held = 1'b0;
          m_drop = 1'b1;
        end
      end
    end else if (e_read) begin
      m_popped = 1'b1;
    end
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic issue_one(input logic [ADDR_WIDTH-1:0] a);
    idle_step();
    step(1'b0, 1'b0, 1'b1, a, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    int issues, first_drop, drops;
    int t2_tid[4];
    bit heavy_demand;
    logic [ADDR_WIDTH-1:0] ra;
    logic [TID_WIDTH-1:0] rt;

    line_mask = ~(ADDR_WIDTH'(LANE_SIZE) - ADDR_WIDTH'(1));
    rst_i = 1'b1;
    model_reset();
    do_reset();

    // Single request through to its response
    idle_step();
    check_eq("t1_read_t0", 64'(s_read), 64'd1);
    step(1'b0, 1'b0, 1'b1, 40'h1040, 1'b1, 1'b0, '0);
    check_eq("t1_valid_t1", 64'(s_valid), 64'd0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    check_eq("t1_valid_t2", 64'(s_valid), 64'd1);
    check_eq("t1_addr", 64'(s_addr), 64'h1040);
    check_eq("t1_tid", 64'(s_tid), 64'd0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    check_eq("t1_busy_inflight", 64'(s_busy), 64'd1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    check_eq("t1_busy_after_rsp", 64'(s_busy), 64'd0);

    // Table fills at four; popping resumes only after a slot frees
    do_reset();
    issues = 0;
    for (int k = 0; k < 24; k++) begin
      step(1'b0, 1'b0, 1'b1, 40'h4000 + ADDR_WIDTH'(k) * 40'h40, 1'b1, 1'b0, '0);
      if (s_valid) begin
        if (issues < 4) t2_tid[issues] = int'(s_tid);
        issues++;
      end
    end
    check_eq("t2_issues", 64'(issues), 64'd4);
    for (int k = 0; k < 4; k++) check_eq("t2_tid_seq", 64'(t2_tid[k]), 64'(k));
    check_eq("t2_full_no_read", 64'(s_read), 64'd0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 4'd2);
    check_eq("t2_read_rsp_cycle", 64'(s_read), 64'd0);
    idle_step();
    check_eq("t2_read_after_free", 64'(s_read), 64'd1);

    // Demand blocks issue until timeout drops the request
    do_reset();
    idle_step();
    step(1'b0, 1'b0, 1'b1, 40'h5000, 1'b0, 1'b0, '0);
    first_drop = -1; drops = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      if (s_drop) begin
        drops++;
        if (first_drop < 0) first_drop = k;
      end
    end
    check_eq("t3_drop_cycle", 64'(first_drop), 64'd16);
    check_eq("t3_drop_count", 64'(drops), 64'd1);

    // Once shown, valid/addr/tid hold through demand until ready
    do_reset();
    idle_step();
    step(1'b0, 1'b0, 1'b1, 40'h3000, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      check_eq("t4_valid_stable", 64'(s_valid), 64'd1);
      check_eq("t4_addr_stable", 64'(s_addr), 64'h3000);
      check_eq("t4_tid_stable", 64'(s_tid), 64'd0);
    end
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    check_eq("t4_issued_busy", 64'(s_busy), 64'd1);
    check_eq("t4_valid_after", 64'(s_valid), 64'd0);

    // Flush in HOLD discards the held request, keeps the table
    do_reset();
    issue_one(40'h6000);
    idle_step();
    step(1'b0, 1'b0, 1'b1, 40'h6040, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    check_eq("t5_valid_flush_cycle", 64'(s_valid), 64'd1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    check_eq("t5_valid_after_flush", 64'(s_valid), 64'd0);
    check_eq("t5_busy_table", 64'(s_busy), 64'd1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    check_eq("t5_rsp_frees", 64'(s_busy), 64'd0);

    // Same line popped while already in flight
    do_reset();
    issue_one(40'h2000);
    idle_step();
    step(1'b0, 1'b0, 1'b1, 40'h2010, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
`ifdef HWPF_ISSUE_DEDUP_EN
    check_eq("t6_dedup_drop", 64'(s_drop), 64'd1);
    check_eq("t6_dedup_no_issue", 64'(s_valid), 64'd0);
`else
    check_eq("t6_issue_valid", 64'(s_valid), 64'd1);
    check_eq("t6_issue_tid", 64'(s_tid), 64'd1);
    check_eq("t6_issue_addr", 64'(s_addr), 64'h2000);
`endif

    // Randomized traffic, including occasional mid-run resets
    do_reset();
    heavy_demand = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 64 == 0) heavy_demand = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      ra = 40'h8000 + ADDR_WIDTH'($urandom_range(0, 7)) * 40'h40 + ADDR_WIDTH'($urandom_range(0, 63));
      if (m_out.size() > 0 && $urandom_range(0, 3) != 0)
        rt = m_out[$urandom_range(0, m_out.size() - 1)].tid;
      else
        rt = TID_WIDTH'($urandom);
      step(heavy_demand ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 4) != 0),
           ra,
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 4) == 0),
           rt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_hwpf_issue_ctrl
`default_nettype wire
